// File: rtl/gt_compare_checker.sv
// Sweep engine for unsigned a > b comparators: drives every operand pair,
// samples dut_y after SETTLE cycles, and counts and records mismatches.
module gt_compare_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic               dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [1:0]         state_dbg
);

    // Handshake: start is a level request with no ready; it is honoured on
    // any edge where busy=0 (IDLE or DONE) and ignored while busy=1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2*WIDTH-1:0] IDX_ONE     = (2*WIDTH)'(1);
    localparam logic [2*WIDTH:0]   ERR_ONE     = (2*WIDTH+1)'(1);

    state_t             state, state_nxt;
    logic [3:0]         settle_cnt, settle_cnt_nxt;
    logic [WIDTH-1:0]   dut_a_nxt, dut_b_nxt;
    logic [2*WIDTH:0]   err_count_nxt;
    logic [WIDTH-1:0]   fail_a_nxt, fail_b_nxt;
    logic               fail_seen, fail_seen_nxt;
    logic [2*WIDTH-1:0] idx, idx_inc;
    logic               sample, mismatch;

    assign idx      = {dut_a, dut_b};
    assign idx_inc  = idx + IDX_ONE;
    assign sample   = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign mismatch = dut_y != (dut_a > dut_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            dut_a      <= dut_a_nxt;
            dut_b      <= dut_b_nxt;
            err_count  <= err_count_nxt;
            fail_a     <= fail_a_nxt;
            fail_b     <= fail_b_nxt;
            fail_seen  <= fail_seen_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        dut_a_nxt      = dut_a;
        dut_b_nxt      = dut_b;
        err_count_nxt  = err_count;
        fail_a_nxt     = fail_a;
        fail_b_nxt     = fail_b;
        fail_seen_nxt  = fail_seen;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = RUN;
                    settle_cnt_nxt = '0;
                    dut_a_nxt      = '0;
                    dut_b_nxt      = '0;
                    err_count_nxt  = '0;
                    fail_a_nxt     = '0;
                    fail_b_nxt     = '0;
                    fail_seen_nxt  = 1'b0;
                end
            end
            RUN: begin
                settle_cnt_nxt = settle_cnt + 4'd1;
                if (sample) begin
                    settle_cnt_nxt = '0;
                    if (mismatch) begin
                        if (err_count != '1)
                            err_count_nxt = err_count + ERR_ONE;
                        if (!fail_seen) begin
                            fail_a_nxt    = dut_a;
                            fail_b_nxt    = dut_b;
                            fail_seen_nxt = 1'b1;
                        end
                    end
                    // The last vector stays on the operand bus after the sweep.
                    if (&idx)
                        state_nxt = DONE;
                    else
                        {dut_a_nxt, dut_b_nxt} = idx_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == '0);
    assign state_dbg = state;

endmodule

// File: tb/tb_gt_compare_checker.sv
// Bench for gt_compare_checker: two instances (SETTLE=2 and SETTLE=1) each
// driving a configurable comparator model, checked against a pair-level reference.
module tb_gt_compare_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start0 = 1'b0, start1 = 1'b0;
    logic [W-1:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic         y0, y1, busy0, busy1, done0, done1, pass0, pass1;
    logic [2*W:0] err0, err1;
    logic [1:0]   st0, st1;

    int mode0 = 0, mode1 = 0;
    bit flip_tab [0:255];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    // Comparator under test: 0 good, 1 stuck-0, 2 stuck-1, 3 a>=b, 4 random flips.
    function automatic logic comp_model(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ia >= ib;
            4:       return (ia > ib) ^ flip_tab[ia*16 + ib];
            default: return ia > ib;
        endcase
    endfunction

    assign y0 = comp_model(mode0, a0, b0);
    assign y1 = comp_model(mode1, a1, b1);

    gt_compare_checker #(.WIDTH(W), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_a(fa0), .fail_b(fb0), .state_dbg(st0));

    gt_compare_checker #(.WIDTH(W), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1), .state_dbg(st1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: walk all pairs in sweep order with y = a > b.
    task automatic ref_model(input int mode, output int errs, output int fa, output int fb);
        bit seen;
        errs = 0; fa = 0; fb = 0; seen = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                if (comp_model(mode, W'(a), W'(b)) != (a > b)) begin
                    errs++;
                    if (!seen) begin fa = a; fb = b; seen = 1; end
                end
    endtask

    task automatic check_reset_vals(input int which, input string tag);
        if (which == 0) begin
            check({tag, "_st0"}, 32'(st0), 0);
            check({tag, "_outs0"}, {busy0, done0, pass0, err0, a0, b0, fa0, fb0}, 0);
        end else begin
            check({tag, "_st1"}, 32'(st1), 0);
            check({tag, "_outs1"}, {busy1, done1, pass1, err1, a1, b1, fa1, fb1}, 0);
        end
    endtask

    task automatic start_sweep(input int which, input bit hold);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        if (which == 0) check("start_state0", {busy0, done0, err0, a0, b0, fa0, fb0}, {2'b10, 25'd0});
        else            check("start_state1", {busy1, done1, err1, a1, b1, fa1, fb1}, {2'b10, 25'd0});
    endtask

    // Counts edges after the start edge until done; checks the vector order on the way.
    task automatic wait_done(input int which, input int settle);
        int n;
        logic d, bz;
        logic [2*W-1:0] idx;
        n = 0;
        d = 1'b0;
        while (!d && n < 256*settle + 20) begin
            @(posedge clk); #1;
            n++;
            d   = (which == 0) ? done0 : done1;
            bz  = (which == 0) ? busy0 : busy1;
            idx = (which == 0) ? {a0, b0} : {a1, b1};
            if (!d) begin
                check("busy_in_run", 32'(bz), 1);
                check("vec_order", 32'(idx), 32'(n / settle));
            end
        end
        check("done_cycles", n, 256*settle);
    endtask

    task automatic check_result(input int which, input int e, input int fa, input int fb, input string tag);
        if (which == 0) begin
            check({tag, "_flags"}, {busy0, done0, pass0}, {2'b01, e == 0});
            check({tag, "_err"}, 32'(err0), e);
            check({tag, "_fail"}, {fa0, fb0}, 32'(fa * 16 + fb));
            check({tag, "_last"}, {a0, b0}, 255);
        end else begin
            check({tag, "_flags"}, {busy1, done1, pass1}, {2'b01, e == 0});
            check({tag, "_err"}, 32'(err1), e);
            check({tag, "_fail"}, {fa1, fb1}, 32'(fa * 16 + fb));
            check({tag, "_last"}, {a1, b1}, 255);
        end
    endtask

    initial begin
        int e, fa, fb;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(0, "reset");
        check_reset_vals(1, "reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed comparator behaviours from the sweep plan.
        mode0 = 0; start_sweep(0, 0); wait_done(0, 2); check_result(0, 0, 0, 0, "good");
        mode0 = 1; start_sweep(0, 0); wait_done(0, 2); check_result(0, 120, 1, 0, "stuck0");
        mode0 = 2; start_sweep(0, 0); wait_done(0, 2); check_result(0, 136, 0, 0, "stuck1");
        mode0 = 3; start_sweep(0, 0); wait_done(0, 2); check_result(0, 16, 0, 0, "ge");
        mode1 = 3; start_sweep(1, 0); wait_done(1, 1); check_result(1, 16, 0, 0, "ge_s1");

        // Randomised fault patterns against the reference walk.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) flip_tab[i] = ($urandom_range(0, 15) == 0);
            ref_model(4, e, fa, fb);
            if (r % 2 == 0) begin
                mode0 = 4; start_sweep(0, 0); wait_done(0, 2); check_result(0, e, fa, fb, "rand_s2");
            end else begin
                mode1 = 4; start_sweep(1, 0); wait_done(1, 1); check_result(1, e, fa, fb, "rand_s1");
            end
        end

        // Reset mid-sweep, with a simultaneous start that must be ignored.
        mode0 = 0;
        start_sweep(0, 0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        check_reset_vals(0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        start0 = 1'b0;
        @(posedge clk); #1;
        check_reset_vals(0, "post_reset_idle");
        start_sweep(0, 0); wait_done(0, 2); check_result(0, 0, 0, 0, "after_reset");

        // Start held throughout RUN, then still high in DONE restarts the sweep.
        mode0 = 1;
        start_sweep(0, 1); wait_done(0, 2); check_result(0, 120, 1, 0, "held");
        @(posedge clk); #1;
        start0 = 1'b0;
        check("restart_state", {busy0, done0, err0, a0, b0, fa0, fb0}, {2'b10, 25'd0});
        wait_done(0, 2); check_result(0, 120, 1, 0, "restarted");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gt_compare_checker.md
# gt_compare_checker

Self-checking sweep engine for the unsigned greater-than comparators (y = a > b). On a start pulse it drives every operand pair onto a comparator instance under test and samples the comparator's y after a fixed settle time. It then checks y against its own reference result, counts mismatches and reports pass/fail. It is the response-checking end of the comparator interface and is intended for on-board (FPGA) bring-up of the comparator blocks.

## Interface
- WIDTH, 4, operand width; the sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 2, number of clock cycles each vector is held before dut_y is sampled; legal range 1..15.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a sweep; level-sampled, acted on only in IDLE or DONE.
- dut_a  output  WIDTH  operand a to comparator; registered.
- dut_b  output  WIDTH  operand b to comparator; registered.
- dut_y  input  1  comparator result (combinational from dut_a/dut_b).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held until the next start or reset.
- pass  output  1  done && err_count == 0.
- err_count  output  2*WIDTH+1  mismatch count; saturates at all-ones.
- fail_a  output  WIDTH  dut_a of first mismatch; 0 if none.
- fail_b  output  WIDTH  dut_b of first mismatch; 0 if none.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> RUN; dut_a=dut_b=0, settle counter=0, err_count=0, fail_a=fail_b=0, first-fail flag cleared.
- RUN: vector index = {dut_a, dut_b}; b is the low (fast-changing) half. Order: (0,0),(0,1)..(0,15),(1,0)..(15,15) for WIDTH=4.
- Settle counter increments each cycle. When it equals SETTLE-1, dut_y is sampled on that edge and compared with the reference (dut_a > dut_b, unsigned).
  - Mismatch: err_count+1 (saturating). If this is the first mismatch, latch fail_a/fail_b and set the first-fail flag.
  - Same edge: settle counter -> 0. If the index is all-ones -> DONE, and dut_a/dut_b hold the last vector. Otherwise the index increments by 1.
- start during RUN is ignored. No abort input; only rst_n stops a sweep.
- DONE: done=1, busy=0. err_count, fail_a and fail_b are held. start=1 -> re-initialise exactly as from IDLE and enter RUN.
- Reset values: state IDLE; dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0.

## Timing
- start sampled high at edge k -> after edge k: busy=1, dut_a=dut_b=0.
- Vector n (0-based) is driven after edge k+n*SETTLE. Its dut_y is sampled at edge k+(n+1)*SETTLE, and the next vector is driven after that same edge.
- Last vector is sampled at edge k+2^(2*WIDTH)*SETTLE. After that edge: done=1, busy=0, pass valid. For WIDTH=4, SETTLE=2 this is edge k+512.
- dut_y must be stable within SETTLE cycles of an operand change. No sampling occurs on the edge that changes the operands unless SETTLE=1. With SETTLE=1 the sample taken at edge t belongs to the vector driven after edge t-1.
- err_count and fail_* update on the sampling edge and are visible the next cycle. pass is combinational from done and err_count.
- rst_n low at any edge, including mid-RUN, forces all reset values after that edge. A start on the same edge as reset is ignored.
- start and rst_n are synchronous to clk. No CDC inside.

## Test plan
- Correct behavioural y = a>b, WIDTH=4, SETTLE=2, start pulse -> busy for 512 cycles, then done=1, pass=1, err_count=0, fail_a=fail_b=0.
- y stuck at 0 -> done with err_count=120 (count of a>b pairs), pass=0, fail_a=1, fail_b=0.
- y stuck at 1 -> err_count=136, fail_a=0, fail_b=0.
- Faulty comparator computing a>=b -> err_count=16 (equal pairs only), fail_a=0, fail_b=0. Repeat with SETTLE=1 -> same result after 256 cycles.
- rst_n low at cycle 100 of a sweep -> all outputs at reset values next cycle, state IDLE. A new start then completes a full 512-cycle sweep with pass=1.
- start held high throughout RUN -> no restart mid-sweep, done at the expected edge. start high again in DONE -> counts cleared and a new sweep begins from (0,0).
